// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MD opcode encoding used by
// both the ID-stage decoder and mdu_ctrl, plus small opcode decode helpers.
package mdu_ctrl_pkg;

   localparam int MDU_WIDTH = 32;

   // 3-bit MD operation codes; codes 3'b110 and 3'b111 are unused/illegal.
   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   // Arithmetic ops (the iterative ones) all have bit 2 clear.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return op[1];
   endfunction

   // Signed variants are the even codes (MULT, DIV).
   function automatic logic md_is_signed(input logic [2:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Combinational core of the MDU: one shift-add / restoring-divide iteration
// on the 2*WIDTH working register, plus the final sign correction.
module mdu_datapath
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     opnd_i,
   input  logic                 neg_res_i,
   input  logic                 neg_rem_i,
   output logic [2*WIDTH-1:0]   step_o,
   output logic [WIDTH-1:0]     hi_o,
   output logic [WIDTH-1:0]     lo_o
);

   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       div_top;
   logic [WIDTH-1:0]     div_diff;
   logic [2*WIDTH-1:0]   prod_neg;
   logic                 neg_quot;

   // One iteration: multiply adds into the upper half then shifts right;
   // divide shifts left and subtracts the divisor when it fits.
   always_comb begin
      add_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      div_top  = acc_i[2*WIDTH-1:WIDTH-1];
      // Only used when div_top >= divisor, so the difference fits in WIDTH bits.
      div_diff = div_top[WIDTH-1:0] - opnd_i;
      if (is_div_i) begin
         if (div_top >= {1'b0, opnd_i}) begin
            step_o = {div_diff, acc_i[WIDTH-2:0], 1'b1};
         end else begin
            step_o = {div_top[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_o = {add_sum, acc_i[WIDTH-1:1]};
      end
   end

   // Sign fix-up; a zero divisor leaves the all-ones quotient un-negated and
   // the remainder (|dividend| re-signed) equal to the raw dividend.
   always_comb begin
      prod_neg = -acc_i;
      neg_quot = neg_res_i & (opnd_i != {WIDTH{1'b0}});
      if (is_div_i) begin
         lo_o = neg_quot  ? -acc_i[WIDTH-1:0]         : acc_i[WIDTH-1:0];
         hi_o = neg_rem_i ? -acc_i[2*WIDTH-1:WIDTH]   : acc_i[2*WIDTH-1:WIDTH];
      end else begin
         {hi_o, lo_o} = neg_res_i ? prod_neg : acc_i;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer beside the EX-stage ALU. Owns HI/LO,
// runs MULT/MULTU/DIV/DIVU in 32 iterations plus a fix-up cycle, and raises
// stall so the front of the pipeline freezes while an operation is in flight.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        MDop,
   input  logic [WIDTH-1:0]  busA,
   input  logic [WIDTH-1:0]  busB,
   input  logic              flush,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [WIDTH-1:0]  HI,
   output logic [WIDTH-1:0]  LO
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, hi_fix, lo_fix;
   logic                 is_div_q, is_div_d;
   logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic                 done_q, done_d;
   logic                 arith_go, mt_go;
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b;

   // Request qualification (only acted on in IDLE); flush kills a same-cycle start.
   assign arith_go = start & ~flush & md_is_arith(MDop);
   assign mt_go    = start & ~flush & ((MDop == MD_MTHI) || (MDop == MD_MTLO));

   // Operand magnitudes for the unsigned core.
   assign sign_a = md_is_signed(MDop) & busA[WIDTH-1];
   assign sign_b = md_is_signed(MDop) & busB[WIDTH-1];
   assign mag_a  = sign_a ? -busA : busA;
   assign mag_b  = sign_b ? -busB : busB;

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .is_div_i  (is_div_q),
      .acc_i     (acc_q),
      .opnd_i    (opnd_q),
      .neg_res_i (neg_res_q),
      .neg_rem_i (neg_rem_q),
      .step_o    (acc_step),
      .hi_o      (hi_fix),
      .lo_o      (lo_fix)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE -> CALC (ITER cycles) -> FIX -> IDLE; flush aborts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (arith_go) state_d = S_CALC;
         S_CALC: begin
            if (flush)                    state_d = S_IDLE;
            else if (cnt_q == {CW{1'b0}}) state_d = S_FIX;
         end
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Working-register and HI/LO next values for each state.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arith_go) begin
               cnt_d     = CW'(ITER - 1);
               is_div_d  = md_is_div(MDop);
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               // Divide: opnd = divisor, low half = dividend.
               // Multiply: opnd = multiplicand, low half = multiplier.
               opnd_d    = md_is_div(MDop) ? mag_b : mag_a;
               acc_d     = {{WIDTH{1'b0}}, (md_is_div(MDop) ? mag_a : mag_b)};
            end else if (mt_go) begin
               if (MDop == MD_MTHI) hi_d = busA;
               else                 lo_d = busA;
            end
         end
         S_CALC: begin
            if (!flush) begin
               acc_d = acc_step;
               if (cnt_q != {CW{1'b0}}) cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            if (!flush) begin
               hi_d   = hi_fix;
               lo_d   = lo_fix;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and architectural registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   // Outputs: busy decodes the registered state; stall also covers the start cycle.
   always_comb begin
      busy  = (state_q != S_IDLE);
      stall = busy | (start & md_is_arith(MDop));
      done  = done_q;
      HI    = hi_q;
      LO    = lo_q;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random
// MULT/MULTU/DIV/DIVU against a plain-arithmetic reference model.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  MDop;
   logic [31:0] busA, busB;
   logic        busy, stall, done;
   logic [31:0] HI, LO;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_hl;

   always #5 clk = ~clk;

   mdu_ctrl #(.WIDTH(32), .ITER(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .MDop  (MDop),
      .busA  (busA),
      .busB  (busB),
      .flush (flush),
      .busy  (busy),
      .stall (stall),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   // Reference: {HI,LO} straight from 64-bit integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [31:0]     q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         MD_MULT:  return sa * sb;
         MD_MULTU: return ua * ub;
         MD_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {r, q};
         end
         MD_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = 32'(ua / ub);
            r = 32'(ua % ub);
            return {r, q};
         end
         default: return 64'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present a request for one edge; expects stall asserted in the start cycle.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      MDop  = op;
      busA  = a;
      busB  = b;
      start = 1'b1;
      #1 check({tag, "/stall"}, 64'(stall), 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
      exp_hl = ref_result(op, a, b);
   endtask

   // Wait (bounded) for done; checks busy length and result. Returns at the done negedge.
   task automatic collect(input string tag);
      int nb   = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 45 && !seen; i++) begin
         @(negedge clk);
         if (done)      seen = 1'b1;
         else if (busy) nb++;
      end
      check({tag, "/done_seen"}, 64'(seen), 64'd1);
      check({tag, "/busy_cycles"}, 64'(nb), 64'd33);
      check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "/result"}, {HI, LO}, exp_hl);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      start_op(op, a, b, tag);
      collect(tag);
      @(negedge clk);
      check({tag, "/done_single"}, 64'(done), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prev;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          ndone;

      rst = 1'b1; start = 1'b0; flush = 1'b0; MDop = 3'd0; busA = '0; busB = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset/busy", 64'(busy), 64'd0);
      check("reset/done", 64'(done), 64'd0);
      check("reset/hilo", {HI, LO}, 64'd0);
      rst = 1'b0;

      // MTHI then MTLO, one edge each, never busy.
      @(negedge clk);
      start = 1'b1; MDop = MD_MTHI; busA = 32'h1234_5678;
      #1 check("mthi/stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      check("mthi/hi", 64'(HI), 64'h1234_5678);
      check("mthi/busy", 64'(busy), 64'd0);
      MDop = MD_MTLO; busA = 32'hCAFE_F00D;
      @(posedge clk); #1 start = 1'b0;
      check("mtlo/hilo", {HI, LO}, 64'h1234_5678_CAFE_F00D);
      check("mtlo/busy", 64'(busy), 64'd0);
      check("mtlo/done", 64'(done), 64'd0);
      @(negedge clk);

      // Directed arithmetic cases.
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_ffff_x2");
      check("multu_ffff_x2/spec", exp_hl, 64'h0000_0001_FFFF_FFFE);
      run_op(MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_m1_x2");
      check("mult_m1_x2/spec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
      check("div_m7_2/spec", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(MD_DIVU,  32'h0000_0064, 32'h0000_0000, "divu_by0");
      check("divu_by0/spec", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf/spec", {HI, LO}, 64'h0000_0000_8000_0000);
      run_op(MD_DIV,   32'hFFFF_FFFB, 32'h0000_0000, "div_neg_by0");
      run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");

      // Illegal opcode: no stall, no state change.
      start = 1'b1; MDop = 3'b110; busA = 32'hDEAD_BEEF; busB = 32'h1;
      #1 check("illegal/stall", 64'(stall), 64'd0);
      @(posedge clk); #1 start = 1'b0;
      check("illegal/busy", 64'(busy), 64'd0);
      check("illegal/hilo", {HI, LO}, exp_hl);
      @(negedge clk);

      // Flush in IDLE suppresses a same-cycle start (arith and MT).
      start = 1'b1; flush = 1'b1; MDop = MD_MULT; busA = 32'd5; busB = 32'd6;
      @(posedge clk); #1;
      check("idle_flush/busy", 64'(busy), 64'd0);
      MDop = MD_MTHI; busA = 32'hAAAA_5555;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      check("idle_flush/hilo", {HI, LO}, exp_hl);
      @(negedge clk);

      // Back-to-back: second start presented in the done cycle.
      start_op(MD_MULTU, 32'h0001_0003, 32'h0002_0005, "b2b_first");
      collect("b2b_first");
      start_op(MD_DIVU, 32'h0000_03E8, 32'h0000_0007, "b2b_second");
      check("b2b_second/busy_after_e0", 64'(busy), 64'd1);
      check("b2b_second/done_after_e0", 64'(done), 64'd0);
      collect("b2b_second");
      @(negedge clk);

      // Flush mid-divide: abort, no done, HI/LO retained; restart later.
      prev = exp_hl;
      start_op(MD_DIVU, 32'h1234_5678, 32'h0000_0013, "flush_div");
      exp_hl = prev;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush/busy", 64'(busy), 64'd0);
      check("flush/done", 64'(done), 64'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("flush/no_done", 64'(ndone), 64'd0);
      check("flush/hilo_kept", {HI, LO}, prev);
      repeat (2) @(negedge clk);
      run_op(MD_DIVU, 32'h1234_5678, 32'h0000_0013, "after_flush");

      // Start ignored while busy, then reset mid-flight.
      start_op(MD_MULT, 32'd7, 32'd9, "rst_mult");
      repeat (4) @(negedge clk);
      start = 1'b1; MDop = MD_MULT; busA = 32'd5; busB = 32'd6;
      #1 check("busy_start/stall", 64'(stall), 64'd1);
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst/busy", 64'(busy), 64'd0);
      check("midrst/done", 64'(done), 64'd0);
      check("midrst/stall", 64'(stall), 64'd0);
      check("midrst/hilo", {HI, LO}, 64'd0);
      run_op(MD_MULT, 32'd3, 32'd4, "mult_3x4");
      check("mult_3x4/spec", {HI, LO}, 64'h0000_0000_0000_000C);

      // Random operations.
      for (int n = 0; n < 24; n++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0)      rb = 32'd0;
         else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
         run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", n, rop));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
